// File: rtl/data_mem_lsu_if.sv
// rtl/data_mem_lsu_if.sv - request/response bus between the core MEM stage and the data memory
interface data_mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  // Core side: issues requests, consumes responses.
  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - byte-addressed data memory with load/store sizing and error reporting
module data_mem_lsu #(
  parameter int                DEPTH     = 128,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic          clk,
  input logic          rst,
  data_mem_lsu_if.slave bus
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [31:0] mem [DEPTH];

  logic              stall;
  logic              s1_valid;
  logic              s1_we;
  logic [ADDR_W-1:0] s1_addr;
  logic [2:0]        s1_funct3;
  logic [31:0]       s1_wdata;

  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;

  logic [ADDR_W-1:0] word_off;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              out_of_range;
  logic              misaligned;
  logic              bad_funct3;
  logic              access_err;
  logic              do_write;
  logic [3:0]        wstrb;
  logic [31:0]       wdata_lane;
  logic [31:0]       rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;

  // A held response blocks both pipeline stages so nothing is overwritten.
  assign stall         = resp_valid_q & ~bus.resp_ready;
  assign bus.req_ready = ~stall;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // Stage 1: capture the accepted request; hold everything while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= bus.req_valid;
      if (bus.req_valid) begin
        s1_we     <= bus.req_we;
        s1_addr   <= bus.req_addr;
        s1_funct3 <= bus.req_funct3;
        s1_wdata  <= bus.req_wdata;
      end
    end
  end

  assign word_off     = (s1_addr - BASE_ADDR) >> 2;
  assign idx          = word_off[IDX_W-1:0];
  assign lane         = s1_addr[1:0];
  assign out_of_range = (s1_addr < BASE_ADDR) || ({1'b0, word_off} >= DEPTH_EXT);
  assign misaligned   = ((s1_funct3 == 3'b001) && lane[0]) ||
                        ((s1_funct3 == 3'b010) && (lane != 2'b00));
  assign bad_funct3   = s1_we ? !(s1_funct3 inside {3'b000, 3'b001, 3'b010})
                              :  (s1_funct3 inside {3'b011, 3'b110, 3'b111});
  assign access_err   = out_of_range | misaligned | bad_funct3;
  assign do_write     = s1_valid & ~stall & ~rst & s1_we & ~access_err;
  assign rd_word      = mem[idx];

  // Byte strobes and lane-replicated store data for the store size.
  always_comb begin
    wstrb      = 4'b0000;
    wdata_lane = s1_wdata;
    case (s1_funct3[1:0])
      2'b00: begin
        wstrb      = 4'b0001 << lane;
        wdata_lane = {4{s1_wdata[7:0]}};
      end
      2'b01: begin
        wstrb      = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{s1_wdata[15:0]}};
      end
      2'b10: begin
        wstrb      = 4'b1111;
        wdata_lane = s1_wdata;
      end
      default: wstrb = 4'b0000;
    endcase
  end

  // Array write: only the selected byte lanes change.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  // Load path: pick the addressed byte/half and extend it.
  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'h0;
    case (lane)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    case (s1_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'h0, byte_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase
  end

  // Stage 2: registered response; stays put while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else if (!stall) begin
      resp_valid_q <= s1_valid;
      if (s1_valid) begin
        resp_err_q   <= access_err;
        resp_rdata_q <= (s1_we || access_err) ? 32'h0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - directed self-checking bench for data_mem_lsu
module tb_data_mem_lsu;

  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  data_mem_lsu_if #(.ADDR_W(32)) bus ();

  data_mem_lsu #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    bus.req_wdata  = wd;
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [2:0] f3, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    drive(we, addr, f3, wd);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk({tag, "_lat"}, bus.resp_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, bus.resp_valid, 1);
    chk({tag, "_rdata"}, bus.resp_rdata, exp_rd);
    chk({tag, "_err"}, bus.resp_err, exp_err);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_funct3 = 3'b000;
    bus.req_wdata = '0;
    bus.resp_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_req_ready", bus.req_ready, 1);

    // Back-to-back SW then LW to the same word.
    drive(1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("sw_lat", bus.resp_valid, 0);
    drive(1'b0, 32'h10, 3'b010, 32'h0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("sw_valid", bus.resp_valid, 1);
    chk("sw_rdata", bus.resp_rdata, 32'h0);
    chk("sw_err", bus.resp_err, 0);
    @(posedge clk); #1;
    chk("lw_valid", bus.resp_valid, 1);
    chk("lw_rdata", bus.resp_rdata, 32'hDEADBEEF);
    chk("lw_err", bus.resp_err, 0);
    @(posedge clk); #1;
    chk("idle_valid", bus.resp_valid, 0);

    // Byte and halfword lanes.
    xact("sb12", 1'b1, 32'h12, 3'b000, 32'h0000007F, 32'h0, 1'b0);
    xact("lb13", 1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0);
    xact("lbu13", 1'b0, 32'h13, 3'b100, 32'h0, 32'h000000DE, 1'b0);
    xact("lh12", 1'b0, 32'h12, 3'b001, 32'h0, 32'hFFFFDE7F, 1'b0);
    xact("lhu10", 1'b0, 32'h10, 3'b101, 32'h0, 32'h0000BEEF, 1'b0);

    // Error cases.
    xact("lw11", 1'b0, 32'h11, 3'b010, 32'h0, 32'h0, 1'b1);
    xact("sw20", 1'b1, 32'h20, 3'b010, 32'h12345678, 32'h0, 1'b0);
    xact("sh21", 1'b1, 32'h21, 3'b001, 32'h0000AAAA, 32'h0, 1'b1);
    xact("lw20", 1'b0, 32'h20, 3'b010, 32'h0, 32'h12345678, 1'b0);
    xact("lw_oor", 1'b0, 32'h40, 3'b010, 32'h0, 32'h0, 1'b1);
    xact("ld_f3_011", 1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1);
    xact("st_f3_100", 1'b1, 32'h10, 3'b100, 32'h0, 32'h0, 1'b1);
    xact("lw10_kept", 1'b0, 32'h10, 3'b010, 32'h0, 32'hDE7FBEEF, 1'b0);

    // Back-pressure with four streamed loads.
    xact("pre0", 1'b1, 32'h00, 3'b010, 32'h11111111, 32'h0, 1'b0);
    xact("pre1", 1'b1, 32'h04, 3'b010, 32'h22222222, 32'h0, 1'b0);
    xact("pre2", 1'b1, 32'h08, 3'b010, 32'h33333333, 32'h0, 1'b0);
    xact("pre3", 1'b1, 32'h0C, 3'b010, 32'h44444444, 32'h0, 1'b0);
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    drive(1'b0, 32'h00, 3'b010, 32'h0);
    @(posedge clk); #1;
    chk("bp_e1_valid", bus.resp_valid, 0);
    chk("bp_e1_ready", bus.req_ready, 1);
    drive(1'b0, 32'h04, 3'b010, 32'h0);
    @(posedge clk); #1;
    chk("bp_e2_rdata", bus.resp_rdata, 32'h11111111);
    chk("bp_e2_ready", bus.req_ready, 0);
    drive(1'b0, 32'h08, 3'b010, 32'h0);
    @(posedge clk); #1;
    chk("bp_e3_valid", bus.resp_valid, 1);
    chk("bp_e3_rdata", bus.resp_rdata, 32'h11111111);
    chk("bp_e3_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    chk("bp_e4_rdata", bus.resp_rdata, 32'h11111111);
    chk("bp_e4_ready", bus.req_ready, 0);
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    chk("bp_e5_rdata", bus.resp_rdata, 32'h22222222);
    drive(1'b0, 32'h0C, 3'b010, 32'h0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("bp_e6_rdata", bus.resp_rdata, 32'h33333333);
    @(posedge clk); #1;
    chk("bp_e7_valid", bus.resp_valid, 1);
    chk("bp_e7_rdata", bus.resp_rdata, 32'h44444444);
    @(posedge clk); #1;
    chk("bp_e8_valid", bus.resp_valid, 0);

    // Reset with a store sitting in stage 1.
    xact("pre30", 1'b1, 32'h30, 3'b010, 32'hCAFE0000, 32'h0, 1'b0);
    drive(1'b1, 32'h30, 3'b010, 32'h00000001);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rmf_valid", bus.resp_valid, 0);
    chk("rmf_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    chk("rmf_valid2", bus.resp_valid, 0);
    xact("lw30", 1'b0, 32'h30, 3'b010, 32'h0, 32'hCAFE0000, 1'b0);

    // Full-throughput store sweep.
    for (int i = 0; i <= DEPTH + 1; i++) begin
      if (i < DEPTH) drive(1'b1, 32'(i * 4), 3'b010, 32'(i));
      else bus.req_valid = 1'b0;
      @(posedge clk); #1;
      if (i >= 1 && i <= DEPTH) begin
        chk($sformatf("sweep_sw%0d_valid", i - 1), bus.resp_valid, 1);
        chk($sformatf("sweep_sw%0d_err", i - 1), bus.resp_err, 0);
      end
    end

    // Full-throughput load sweep.
    for (int i = 0; i <= DEPTH + 1; i++) begin
      if (i < DEPTH) drive(1'b0, 32'(i * 4), 3'b010, 32'h0);
      else bus.req_valid = 1'b0;
      @(posedge clk); #1;
      if (i >= 1 && i <= DEPTH) begin
        chk($sformatf("sweep_lw%0d_valid", i - 1), bus.resp_valid, 1);
        chk($sformatf("sweep_lw%0d_rdata", i - 1), bus.resp_rdata, 32'(i - 1));
        chk($sformatf("sweep_lw%0d_err", i - 1), bus.resp_err, 0);
      end
    end
    chk("sweep_end_valid", bus.resp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
